// File: rtl/mmul_reg_unload_if.sv
// Handshake bundle between the Montgomery datapath result path and the bus side:
// serial capture inputs, word unload handshake and status.
interface mmul_reg_unload_if #(
    parameter int WORD = 16
);
    logic            start;
    logic            bit_in;
    logic            bit_vld;
    logic [WORD-1:0] word_out;
    logic            word_vld;
    logic            word_rdy;
    logic            busy;
    logic            done;

    // Environment side: drives capture inputs and downstream ready.
    modport master (
        output start, bit_in, bit_vld, word_rdy,
        input  word_out, word_vld, busy, done
    );

    // Unloader side.
    modport slave (
        input  start, bit_in, bit_vld, word_rdy,
        output word_out, word_vld, busy, done
    );
endinterface

// File: rtl/mmul_reg_unload.sv
// Result deserializer/unloader: collects a WIDTH-bit result MSB-first one bit
// per cycle, then drains it as NWORD words of WORD bits, least-significant word
// first, over a valid/ready handshake. done pulses the cycle after the last word.
module mmul_reg_unload #(
    parameter int WIDTH = 256,
    parameter int WORD  = 16,
    parameter int NWORD = 16
) (
    input logic              clk,
    input logic              rst,
    mmul_reg_unload_if.slave bus
);
    localparam int BCW = $clog2(WIDTH);
    localparam int WCW = $clog2(NWORD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   sr;
    logic [BCW-1:0]     bit_cnt;
    logic [WCW-1:0]     word_cnt;
    logic               done_r;

    logic               clear;
    logic               capture;
    logic               last_bit;
    logic               unload;
    logic               finish;

    // Next-state and datapath strobes; all stray inputs are simply not decoded
    // in states where they must be ignored.
    always_comb begin
        state_nx = state;
        clear    = 1'b0;
        capture  = 1'b0;
        last_bit = 1'b0;
        unload   = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = COLLECT;
                    clear    = 1'b1;
                end
            end
            COLLECT: begin
                if (bus.bit_vld) begin
                    capture = 1'b1;
                    if (bit_cnt == BCW'(WIDTH - 1)) begin
                        last_bit = 1'b1;
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (bus.word_rdy) begin
                    unload = 1'b1;
                    if (word_cnt == WCW'(NWORD - 1)) begin
                        state_nx = IDLE;
                        finish   = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and the one-cycle done pulse following the final handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done_r <= 1'b0;
        end else begin
            state  <= state_nx;
            done_r <= finish;
        end
    end

    // Shift register and counters: shift left on capture, shift right by a word on unload.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
        end else if (clear) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (capture) begin
            sr      <= {sr[WIDTH-2:0], bus.bit_in};
            bit_cnt <= bit_cnt + BCW'(1);
            if (last_bit) begin
                word_cnt <= '0;
            end
        end else if (unload) begin
            sr       <= sr >> WORD;
            word_cnt <= word_cnt + WCW'(1);
        end
    end

    assign bus.word_vld = (state == DRAIN);
    assign bus.word_out = (state == DRAIN) ? sr[WORD-1:0] : '0;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_r;
endmodule

// File: tb/tb_mmul_reg_unload.sv
// Bench for mmul_reg_unload: randomized handshake/gap stimulus against a
// behavioural model holding the whole result and indexing words directly.
module tb_mmul_reg_unload;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmul_reg_unload_if bus ();

    mmul_reg_unload dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    // Model state: phase 0=idle 1=collecting 2=draining.
    int           m_phase;
    int           m_nbits;
    int           m_widx;
    bit           m_done;
    logic [255:0] m_res;

    logic [15:0]  acc[$];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, got, exp);
    endtask

    // Behavioural model: bit n of the stream lands at result bit 255-n; word k is result[16k+:16].
    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0; m_nbits <= 0; m_widx <= 0; m_done <= 1'b0; m_res <= '0;
        end else begin
            m_done <= 1'b0;
            case (m_phase)
                0: if (bus.start) begin
                    m_phase <= 1; m_nbits <= 0; m_res <= '0;
                end
                1: if (bus.bit_vld) begin
                    m_res[255 - m_nbits] <= bus.bit_in;
                    m_nbits <= m_nbits + 1;
                    if (m_nbits == 255) begin m_phase <= 2; m_widx <= 0; end
                end
                2: if (bus.word_rdy) begin
                    m_widx <= m_widx + 1;
                    if (m_widx == 15) begin m_phase <= 0; m_done <= 1'b1; end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Per-cycle compare against the model, and capture of accepted words.
    always @(negedge clk) begin
        if (chk_en) begin
            check("word_vld", 256'(bus.word_vld), 256'(m_phase == 2));
            check("word_out", 256'(bus.word_out), (m_phase == 2) ? 256'(m_res[16*m_widx +: 16]) : 256'(0));
            check("busy", 256'(bus.busy), 256'(m_phase != 0));
            check("done", 256'(bus.done), 256'(m_done));
            if (!rst && bus.word_vld && bus.word_rdy) acc.push_back(bus.word_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a capture and shift v in MSB-first. gap: 0 continuous, 1 alternate.
    task automatic send(input logic [255:0] v, input int gap, input bit stray);
        int cnt;
        cnt = 0;
        bus.start = 1'b1;
        bus.bit_vld = 1'b0;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 4000 && cnt < 256; c++) begin
            bus.bit_vld = (gap == 1) ? (c % 2 == 0) : 1'b1;
            bus.bit_in  = v[255 - cnt];
            bus.start   = stray ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
            if (bus.bit_vld) cnt++;
        end
        bus.bit_vld = 1'b0;
        bus.start   = 1'b0;
        if (cnt < 256) check("collect_timeout", 256'(cnt), 256'(256));
    endtask

    // Drain up to limit words. pol: 0 always ready, 1 stall word 3 then random, 2 random with stray inputs.
    task automatic drain(input logic [255:0] v, input int pol, input int limit);
        int hs;
        int stall;
        hs = 0;
        stall = 0;
        for (int c = 0; c < 2000 && hs < limit; c++) begin
            if (pol == 0) bus.word_rdy = 1'b1;
            else if (pol == 1 && hs < 3) bus.word_rdy = 1'b1;
            else if (pol == 1 && hs == 3 && stall < 7) begin
                bus.word_rdy = 1'b0;
                stall++;
                if (stall == 7) check("stall_word", 256'(bus.word_out), 256'(v[63:48]));
            end else bus.word_rdy = 1'($urandom_range(0, 1));
            if (pol == 2) begin
                bus.start   = 1'($urandom_range(0, 1));
                bus.bit_vld = 1'($urandom_range(0, 1));
                bus.bit_in  = 1'($urandom_range(0, 1));
            end
            if (bus.word_vld && bus.word_rdy) hs++;
            step();
        end
        bus.word_rdy = 1'b0;
        bus.start    = 1'b0;
        bus.bit_vld  = 1'b0;
        if (hs < limit) check("drain_timeout", 256'(hs), 256'(limit));
    endtask

    task automatic check_result(input string name, input logic [255:0] v);
        logic [255:0] g;
        g = '0;
        check({name, "_nwords"}, 256'(acc.size()), 256'(16));
        for (int i = 0; i < 16 && i < acc.size(); i++) g[16*i +: 16] = acc[i];
        check(name, g, v);
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [255:0] v1, v2;
        bus.start = 1'b0; bus.bit_in = 1'b0; bus.bit_vld = 1'b0; bus.word_rdy = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_word_out", 256'(bus.word_out), 256'(0));
        check("reset_busy", 256'(bus.busy), 256'(0));

        // Basic unload with pinned literal words.
        v1 = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
        acc.delete();
        send(v1, 0, 1'b0);
        check("first_word_vld", 256'(bus.word_vld), 256'(1));
        check("first_word", 256'(bus.word_out), 256'(16'hE1F0));
        drain(v1, 0, 16);
        check("done_pulse", 256'(bus.done), 256'(1));
        check("busy_at_done", 256'(bus.busy), 256'(0));
        check("vld_at_done", 256'(bus.word_vld), 256'(0));
        check_result("basic", v1);
        check("basic_w1", 256'(acc[1]), 256'(16'hC3D2));
        check("basic_w15", 256'(acc[15]), 256'(16'h0123));
        step();
        check("done_one_cycle", 256'(bus.done), 256'(0));

        // Reset mid-drain after 5 accepted words.
        v1 = rnd256();
        send(v1, 0, 1'b0);
        drain(v1, 0, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_vld", 256'(bus.word_vld), 256'(0));
        check("rst_busy", 256'(bus.busy), 256'(0));
        check("rst_word", 256'(bus.word_out), 256'(0));
        step();
        check("rst_no_done", 256'(bus.done), 256'(0));
        v2 = rnd256();
        acc.delete();
        send(v2, 0, 1'b0);
        drain(v2, 0, 16);
        check_result("after_reset", v2);
        step();

        // Gapped all-ones input.
        v1 = '1;
        acc.delete();
        send(v1, 1, 1'b0);
        drain(v1, 0, 16);
        check_result("gapped", v1);
        step();

        // Back-pressure on word 3, then random ready.
        v1 = rnd256();
        acc.delete();
        send(v1, 0, 1'b0);
        drain(v1, 1, 16);
        check_result("backpressure", v1);
        step();

        // Stray inputs in idle, collect and drain; back-to-back from the done cycle.
        bus.bit_vld = 1'b1; bus.bit_in = 1'b1;
        repeat (4) step();
        bus.bit_vld = 1'b0;
        v1 = rnd256();
        v2 = rnd256();
        acc.delete();
        send(v1, 0, 1'b1);
        drain(v1, 2, 16);
        check_result("stray_first", v1);
        acc.delete();
        send(v2, 0, 1'b1);
        drain(v2, 2, 16);
        check_result("stray_second", v2);
        repeat (2) step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mmul_reg_unload.md
Name: mmul_reg_unload

Overview:
Bit-serial-to-word deserializer and result unloader for the Montgomery multiplier datapath. It is the inverse of the operand-B load/shift register. It captures a 256-bit result arriving MSB-first, one bit per cycle. It then drains the result as sixteen 16-bit words, least-significant word first, over a valid/ready handshake to the external bus.

Parameters:
WIDTH, 256, result width in bits; must equal WORD*NWORD
WORD, 16, output word width in bits
NWORD, 16, number of output words per result

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a new capture; sampled only in IDLE
bit_in  input  1  serial result bit, MSB (bit 255) first
bit_vld  input  1  bit_in is valid this cycle; ignored outside COLLECT
word_out  output  16  current output word, equal to result[16*k+15:16*k] for word k
word_vld  output  1  word_out is valid
word_rdy  input  1  downstream accepts word_out when word_vld && word_rdy
busy  output  1  high in COLLECT or DRAIN
done  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, shift register=0, bit_cnt=0, word_cnt=0. Outputs word_out=0, word_vld=0, busy=0, done=0. Reset wins over every other input, including mid-COLLECT or mid-DRAIN; the partial result is discarded.
- Register width and counters: 256-bit shift register sr; bit_cnt 8 bits; word_cnt 4 bits.
- IDLE:
  - start=1 -> COLLECT, bit_cnt=0, sr=0.
  - bit_vld and word_rdy are ignored.
  - busy=0.
- COLLECT:
  - Each cycle with bit_vld=1: sr <= {sr[254:0], bit_in}, bit_cnt += 1. Cycles with bit_vld=0 hold state; gaps are allowed.
  - On the edge that accepts the 256th bit (bit_cnt==255 && bit_vld): -> DRAIN, word_cnt=0. word_vld rises in the next cycle, i.e. 1-cycle latency from the last bit to the first word.
  - start is ignored while in COLLECT.
- DRAIN:
  - word_vld=1 and word_out=sr[15:0].
  - On a handshake (word_vld && word_rdy): sr <= sr >> 16 (zero fill), word_cnt += 1.
  - word_rdy=0: word_out and word_vld hold stable with no change. Back-pressure of any length is legal.
  - Handshake with word_cnt==15: -> IDLE and done=1 for exactly the following cycle. word_vld=0 in that cycle.
  - start and bit_vld are ignored while in DRAIN.
- done cycle: the block is already in IDLE, so start=1 in the done cycle is accepted. This gives back-to-back results.
- Throughput: with word_rdy held high, one word per cycle. A full result takes 256 + 16 cycles minimum.
- word_out is 0 whenever state != DRAIN.

Test Plan:
1. Reset mid-DRAIN. Stimulus: assert rst for one cycle after 5 accepted words. Required: next cycle word_vld=0, busy=0, word_out=0, no done pulse. A subsequent start plus 256 bits plus 16 handshakes yields a correct new result.
2. Basic unload. Stimulus: start; shift in 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0 MSB-first with continuous bit_vld; word_rdy=1. Required: word_vld rises 1 cycle after the 256th bit. Words out in order 0xE1F0, 0xC3D2, ..., 0x0123. done pulses one cycle after word 15, and busy drops in that same cycle.
3. Gapped input. Stimulus: bit_vld toggled 1/0 every cycle over 512 cycles with the all-ones result. Required: exactly 16 words of 0xFFFF. bit_vld=0 cycles must not advance bit_cnt.
4. Back-pressure. Stimulus: word_rdy low for 7 cycles on word 3, then random 50% thereafter. Required: word_out stays at word 3's value while stalled. The sequence contains no dropped or duplicated words, and exactly 16 handshakes occur.
5. Ignored inputs and back-to-back. Stimulus: start pulses during COLLECT and DRAIN; bit_vld=1 during DRAIN and IDLE; start asserted in the done cycle. Required: the stray pulses have no effect on the current result. The second capture begins immediately from the start in the done cycle, and both results are correct.
